// File: rtl/player_controller_if.sv
// Player controller bundle: keyboard/collision/checkpoint inputs in, player position and pulses out.
// master = player_controller side, slave = keyboard/enemy/renderer side.
interface player_controller_if;
   logic [7:0] keycode;
   logic       collision;
   logic       goal;
   logic [9:0] spawn_x;
   logic [9:0] spawn_y;
   logic [9:0] PlayerX;
   logic [9:0] PlayerY;
   logic [9:0] PlayerS;
   logic       start_enemies;
   logic       level_clear;
   logic [3:0] alpha;
   logic [9:0] deaths;
   logic       alive;

   modport master (
      input  keycode, collision, goal, spawn_x, spawn_y,
      output PlayerX, PlayerY, PlayerS, start_enemies, level_clear, alpha, deaths, alive
   );
   modport slave (
      output keycode, collision, goal, spawn_x, spawn_y,
      input  PlayerX, PlayerY, PlayerS, start_enemies, level_clear, alpha, deaths, alive
   );
endinterface

// File: rtl/player_controller.sv
// Per-frame player FSM (SPAWN/ALIVE/DYING): movement with clamping, death fade, respawn pulses.
// One-frame latency from inputs to registered outputs; no backpressure, every frame is consumed.
module player_controller #(
   parameter int SIZE         = 10,
   parameter int SPEED        = 1,
   parameter int X_MIN        = 20,
   parameter int X_MAX        = 620,
   parameter int Y_MIN        = 20,
   parameter int Y_MAX        = 460,
   parameter int DEATH_FRAMES = 32
) (
   input  logic                frame_clk,
   input  logic                Reset,
   player_controller_if.master pif
);
   localparam int            CW      = $clog2(DEATH_FRAMES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [9:0]    SPD     = 10'(SPEED);
   localparam logic [7:0]    KEY_W   = 8'h1A;
   localparam logic [7:0]    KEY_A   = 8'h04;
   localparam logic [7:0]    KEY_S   = 8'h16;
   localparam logic [7:0]    KEY_D   = 8'h07;

   typedef enum logic [1:0] {SPAWN, ALIVE, DYING} state_t;

   state_t        state_q, state_d;
   logic [9:0]    x_q, x_d, y_q, y_d;
   logic [9:0]    deaths_q, deaths_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          start_q, start_d;
   logic          clear_q, clear_d;
   logic          do_spawn;
   logic [10:0]   x_inc, y_inc;
   logic [CW-1:0] remain;

   assign x_inc  = {1'b0, x_q} + {1'b0, SPD};
   assign y_inc  = {1'b0, y_q} + {1'b0, SPD};
   assign remain = ~cnt_q;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      deaths_d = deaths_q;
      cnt_d    = cnt_q;
      start_d  = 1'b0;
      clear_d  = 1'b0;
      do_spawn = 1'b0;
      case (state_q)
         // SPAWN with start low only exists right after Reset: the next frame is the real spawn.
         SPAWN: begin
            if (!start_q) do_spawn = 1'b1;
            else          state_d  = ALIVE;
         end
         ALIVE: begin
            if (pif.collision) begin
               state_d = DYING;
               cnt_d   = '0;
               if (deaths_q != 10'h3FF) deaths_d = deaths_q + 10'd1;
            end else if (pif.goal) begin
               do_spawn = 1'b1;
               clear_d  = 1'b1;
            end else begin
               case (pif.keycode)
                  KEY_D: x_d = (x_inc > 11'(X_MAX)) ? 10'(X_MAX) : x_inc[9:0];
                  KEY_A: x_d = (x_q < 10'(X_MIN + SPEED)) ? 10'(X_MIN) : x_q - SPD;
                  KEY_S: y_d = (y_inc > 11'(Y_MAX)) ? 10'(Y_MAX) : y_inc[9:0];
                  KEY_W: y_d = (y_q < 10'(Y_MIN + SPEED)) ? 10'(Y_MIN) : y_q - SPD;
                  default: ;
               endcase
            end
         end
         DYING: begin
            if (cnt_q == '1) do_spawn = 1'b1;
            else             cnt_d    = cnt_q + CNT_ONE;
         end
         default: state_d = SPAWN;
      endcase
      if (do_spawn) begin
         state_d = SPAWN;
         x_d     = pif.spawn_x;
         y_d     = pif.spawn_y;
         cnt_d   = '0;
         start_d = 1'b1;
      end
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q  <= SPAWN;
         x_q      <= pif.spawn_x;
         y_q      <= pif.spawn_y;
         deaths_q <= '0;
         cnt_q    <= '0;
         start_q  <= 1'b0;
         clear_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         deaths_q <= deaths_d;
         cnt_q    <= cnt_d;
         start_q  <= start_d;
         clear_q  <= clear_d;
      end
   end

   // Fade uses the top four bits of the frames remaining in DYING.
   assign pif.alpha         = (state_q == DYING) ? remain[CW-1 -: 4] : 4'hF;
   assign pif.PlayerX       = x_q;
   assign pif.PlayerY       = y_q;
   assign pif.PlayerS       = 10'(SIZE);
   assign pif.start_enemies = start_q;
   assign pif.level_clear   = clear_q;
   assign pif.deaths        = deaths_q;
   assign pif.alive         = (state_q == ALIVE);
endmodule

// File: tb/tb_player_controller.sv
// Bench for player_controller: directed scenarios plus random frames against a frame-level model.
module tb_player_controller;
   localparam int X_MIN = 20, X_MAX = 620, Y_MIN = 20, Y_MAX = 460, DF = 32;
   localparam int P_HELD = 0, P_SPAWN = 1, P_ALIVE = 2, P_DYING = 3;

   logic frame_clk = 1'b0;
   logic Reset     = 1'b1;
   player_controller_if pif ();

   player_controller dut (.frame_clk(frame_clk), .Reset(Reset), .pif(pif));

   always #5 frame_clk = ~frame_clk;

   int total = 0, bad = 0;
   int m_phase = P_HELD, m_x = 0, m_y = 0, m_deaths = 0, m_age = 0, m_lc = 0;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      total++;
      if (act !== 32'(exp)) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   task enter_spawn();
      m_phase = P_SPAWN;
      m_x     = int'(pif.spawn_x);
      m_y     = int'(pif.spawn_y);
   endtask

   // Frame-level reference: what each new frame should look like given the inputs seen at its start.
   always @(posedge frame_clk) begin
      int dx, dy;
      dx = 0;
      dy = 0;
      if (Reset) begin
         m_phase = P_HELD; m_x = int'(pif.spawn_x); m_y = int'(pif.spawn_y);
         m_deaths = 0; m_age = 0; m_lc = 0;
      end else begin
         m_lc = 0;
         case (m_phase)
            P_HELD:  enter_spawn();
            P_SPAWN: m_phase = P_ALIVE;
            P_ALIVE: begin
               if (pif.collision) begin
                  m_phase  = P_DYING;
                  m_age    = 0;
                  m_deaths = (m_deaths + 1 > 1023) ? 1023 : m_deaths + 1;
               end else if (pif.goal) begin
                  enter_spawn();
                  m_lc = 1;
               end else begin
                  if (pif.keycode == 8'h07) dx = 1;
                  if (pif.keycode == 8'h04) dx = -1;
                  if (pif.keycode == 8'h16) dy = 1;
                  if (pif.keycode == 8'h1A) dy = -1;
                  m_x = clamp(m_x + dx, X_MIN, X_MAX);
                  m_y = clamp(m_y + dy, Y_MIN, Y_MAX);
               end
            end
            default: begin
               if (m_age == DF - 1) enter_spawn();
               else                 m_age++;
            end
         endcase
      end
   end

   always @(negedge frame_clk) begin
      check("x", pif.PlayerX, m_x);
      check("y", pif.PlayerY, m_y);
      check("size", pif.PlayerS, 10);
      check("deaths", pif.deaths, m_deaths);
      check("start", pif.start_enemies, (m_phase == P_SPAWN) ? 1 : 0);
      check("lclear", pif.level_clear, m_lc);
      check("alive", pif.alive, (m_phase == P_ALIVE) ? 1 : 0);
      check("alpha", pif.alpha, (m_phase == P_DYING) ? ((DF - 1 - m_age) * 16) / DF : 15);
   end

   task automatic frames(input int n);
      repeat (n) @(negedge frame_clk);
   endtask

   task automatic wait_alive(input int lim);
      int n = 0;
      while (!pif.alive && n < lim) begin
         @(negedge frame_clk);
         n++;
      end
      check("wait_alive", pif.alive, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_r[5] = '{619, 620, 620, 620, 620};
      pif.keycode = 8'h00; pif.collision = 1'b0; pif.goal = 1'b0;
      pif.spawn_x = 10'd40; pif.spawn_y = 10'd240;
      frames(2);
      check("rst_start", pif.start_enemies, 0);
      check("rst_alpha", pif.alpha, 15);
      check("rst_x", pif.PlayerX, 40);
      Reset = 1'b0;
      frames(1);
      check("spawn_start", pif.start_enemies, 1);
      check("spawn_x", pif.PlayerX, 40);
      check("spawn_y", pif.PlayerY, 240);
      check("spawn_alive", pif.alive, 0);
      frames(1);
      check("first_alive", pif.alive, 1);
      check("first_start", pif.start_enemies, 0);

      // Right-edge clamp from a 618 checkpoint, then left-edge clamp from 21.
      pif.spawn_x = 10'd618; pif.goal = 1'b1;
      frames(1);
      check("goal_lc", pif.level_clear, 1);
      check("goal_start", pif.start_enemies, 1);
      check("goal_x", pif.PlayerX, 618);
      pif.goal = 1'b0; pif.keycode = 8'h07;
      frames(1);
      for (int i = 0; i < 5; i++) begin
         frames(1);
         check("right_clamp", pif.PlayerX, exp_r[i]);
      end
      pif.spawn_x = 10'd21; pif.keycode = 8'h00; pif.goal = 1'b1;
      frames(1);
      pif.goal = 1'b0; pif.keycode = 8'h04;
      frames(1);
      check("left_start", pif.PlayerX, 21);
      for (int i = 0; i < 3; i++) begin
         frames(1);
         check("left_clamp", pif.PlayerX, 20);
      end

      // Death fade with D held: position frozen, alpha ramps down over 32 frames.
      pif.keycode = 8'h07; pif.collision = 1'b1;
      frames(1);
      pif.collision = 1'b0;
      check("die_deaths", pif.deaths, 1);
      check("die_alive", pif.alive, 0);
      check("die_alpha0", pif.alpha, 15);
      for (int i = 1; i < 32; i++) begin
         frames(1);
         check("die_frozen", pif.PlayerX, 20);
         if (i == 1)  check("die_alpha1", pif.alpha, 15);
         if (i == 2)  check("die_alpha2", pif.alpha, 14);
         if (i == 31) check("die_alpha31", pif.alpha, 0);
      end
      frames(1);
      check("respawn_start", pif.start_enemies, 1);
      check("respawn_x", pif.PlayerX, 21);
      pif.keycode = 8'h00;
      frames(1);

      // Collision held through DYING and SPAWN counts once.
      pif.collision = 1'b1;
      frames(34);
      check("held_deaths", pif.deaths, 2);
      check("held_alive", pif.alive, 1);
      frames(1);
      check("held_again", pif.deaths, 3);
      pif.collision = 1'b0;
      wait_alive(40);

      pif.collision = 1'b1; pif.goal = 1'b1;
      frames(1);
      check("both_lc", pif.level_clear, 0);
      check("both_deaths", pif.deaths, 4);
      pif.collision = 1'b0; pif.goal = 1'b0;
      wait_alive(40);
      pif.goal = 1'b1;
      frames(1);
      check("goal2_lc", pif.level_clear, 1);
      check("goal2_start", pif.start_enemies, 1);
      check("goal2_deaths", pif.deaths, 4);
      pif.goal = 1'b0;
      frames(1);

      // Reset in the middle of the fade.
      pif.collision = 1'b1;
      frames(1);
      pif.collision = 1'b0;
      frames(10);
      Reset = 1'b1;
      frames(1);
      check("mid_rst_deaths", pif.deaths, 0);
      check("mid_rst_alpha", pif.alpha, 15);
      check("mid_rst_alive", pif.alive, 0);
      Reset = 1'b0;
      frames(2);

      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 4))
            0: pif.keycode = 8'h1A;
            1: pif.keycode = 8'h04;
            2: pif.keycode = 8'h16;
            3: pif.keycode = 8'h07;
            default: pif.keycode = 8'($urandom);
         endcase
         pif.collision = ($urandom_range(0, 19) == 0);
         pif.goal      = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 49) == 0) begin
            pif.spawn_x = 10'($urandom_range(X_MIN, X_MAX));
            pif.spawn_y = 10'($urandom_range(Y_MIN, Y_MAX));
         end
         Reset = ($urandom_range(0, 299) == 0);
         frames(1);
      end

      // Saturation: collision held forever produces one death per 34 frames.
      Reset = 1'b1; pif.collision = 1'b0; pif.goal = 1'b0;
      frames(1);
      Reset = 1'b0; pif.collision = 1'b1;
      frames(1030 * 34);
      check("deaths_sat", pif.deaths, 1023);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
